// File: rtl/status_array_arbiter_pkg.sv
// Shared constants and types for the status array arbiter.
package status_array_arbiter_pkg;

  // Status array geometry shared with the rest of the cache.
  localparam int STATUS_ADDR_WIDTH = 4;
  localparam int STATUS_ROW_WIDTH  = 16;
  localparam int STATUS_NUM_BLOCKS = 2;

  // Default macro read latency, in cycles after the request on the array port.
  localparam int STATUS_RD_LATENCY = 1;

  // Arbiter states: initializer owns the port, then normal run traffic.
  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/status_read_tracker.sv
// Valid/tag delay line matching the status array read latency.
module status_read_tracker #(
  parameter int RD_LATENCY = 1,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 rvalid_o,
  output logic [TAG_WIDTH-1:0] rtag_o
);

  logic [RD_LATENCY-1:0] vld_q;
  logic [TAG_WIDTH-1:0]  tag_q [RD_LATENCY];

  // Valid bits are control: cleared on reset so in-flight reads are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= push_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Tags are payload and only meaningful where the matching valid is set.
  always_ff @(posedge clk) begin
    tag_q[0] <= tag_i;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_q[i] <= tag_q[i-1];
    end
  end

  assign rvalid_o = vld_q[RD_LATENCY-1];
  assign rtag_o   = rvalid_o ? tag_q[RD_LATENCY-1] : '0;

endmodule

// File: rtl/status_array_arbiter.sv
// Single-port status array arbiter: initializer, update writes and lookup
// reads share the port; lookups win unless an update has waited too long.
module status_array_arbiter
  import status_array_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = STATUS_ADDR_WIDTH,
  parameter int ROW_WIDTH    = STATUS_ROW_WIDTH,
  parameter int NUM_BLOCKS   = STATUS_NUM_BLOCKS,
  parameter int RD_LATENCY   = STATUS_RD_LATENCY,
  parameter int TAG_WIDTH    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_halt,
  input  logic                  i_init_complete,
  input  logic [ADDR_WIDTH-1:0] i_init_addr,
  input  logic [ROW_WIDTH-1:0]  i_init_data,
  input  logic                  i_init_wen,
  input  logic [NUM_BLOCKS-1:0] i_init_wmask,
  input  logic                  i_init_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_addr,
  input  logic [ROW_WIDTH-1:0]  i_upd_data,
  input  logic [NUM_BLOCKS-1:0] i_upd_wmask,
  input  logic                  i_upd_valid,
  output logic                  o_upd_ready,
  input  logic [ADDR_WIDTH-1:0] i_lkp_addr,
  input  logic [TAG_WIDTH-1:0]  i_lkp_tag,
  input  logic                  i_lkp_valid,
  output logic                  o_lkp_ready,
  output logic [ROW_WIDTH-1:0]  o_lkp_rdata,
  output logic [TAG_WIDTH-1:0]  o_lkp_rtag,
  output logic                  o_lkp_rvalid,
  output logic [ADDR_WIDTH-1:0] o_arr_addr,
  output logic [ROW_WIDTH-1:0]  o_arr_data,
  output logic                  o_arr_wen,
  output logic [NUM_BLOCKS-1:0] o_arr_wmask,
  output logic                  o_arr_valid,
  input  logic [ROW_WIDTH-1:0]  i_arr_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      starve_cnt_q;
  logic [TAG_WIDTH-1:0]  arr_tag_q;
  logic                  starve_hit;
  logic                  init_gnt, upd_gnt, lkp_gnt;
  logic                  upd_rdy, lkp_rdy;
  logic                  rd_push;

  assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // Next state: leave init once the initializer reports completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (i_init_complete) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Ready/grant decode: lookup first, update when alone or when starved.
  always_comb begin
    init_gnt = 1'b0;
    upd_rdy  = 1'b0;
    lkp_rdy  = 1'b0;
    if (!i_halt) begin
      case (state_q)
        S_INIT: init_gnt = i_init_valid;
        S_RUN: begin
          lkp_rdy = !(i_upd_valid && starve_hit);
          upd_rdy = !i_lkp_valid || starve_hit;
        end
        default: ;
      endcase
    end
    upd_gnt = upd_rdy && i_upd_valid;
    lkp_gnt = lkp_rdy && i_lkp_valid;
  end

  assign o_upd_ready = upd_rdy;
  assign o_lkp_ready = lkp_rdy;

  // Starvation counter: counts lookups that overtake a waiting update.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else if (upd_gnt || !i_upd_valid) begin
      starve_cnt_q <= '0;
    end else if (lkp_gnt && !starve_hit) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  // Array port register: the granted request appears one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_arr_valid <= 1'b0;
      o_arr_wen   <= 1'b0;
      o_arr_wmask <= '0;
      o_arr_addr  <= '0;
      o_arr_data  <= '0;
      arr_tag_q   <= '0;
    end else begin
      o_arr_valid <= 1'b0;
      o_arr_wen   <= 1'b0;
      o_arr_wmask <= '0;
      o_arr_addr  <= '0;
      o_arr_data  <= '0;
      arr_tag_q   <= '0;
      if (init_gnt) begin
        o_arr_valid <= 1'b1;
        o_arr_wen   <= i_init_wen;
        o_arr_wmask <= i_init_wmask;
        o_arr_addr  <= i_init_addr;
        o_arr_data  <= i_init_data;
      end else if (upd_gnt) begin
        o_arr_valid <= 1'b1;
        o_arr_wen   <= 1'b1;
        o_arr_wmask <= i_upd_wmask;
        o_arr_addr  <= i_upd_addr;
        o_arr_data  <= i_upd_data;
      end else if (lkp_gnt) begin
        o_arr_valid <= 1'b1;
        o_arr_addr  <= i_lkp_addr;
        arr_tag_q   <= i_lkp_tag;
      end
    end
  end

  assign rd_push = o_arr_valid && !o_arr_wen;

  status_read_tracker #(
    .RD_LATENCY (RD_LATENCY),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_rd_trk (
    .clk      (clk),
    .rst      (rst),
    .push_i   (rd_push),
    .tag_i    (arr_tag_q),
    .rvalid_o (o_lkp_rvalid),
    .rtag_o   (o_lkp_rtag)
  );

  assign o_lkp_rdata = o_lkp_rvalid ? i_arr_rdata : '0;

endmodule

// File: doc/status_array_arbiter.md
Name: status_array_arbiter

Overview:
- Owns the single port of the status array and shares it between three requesters: the array initializer, the fill/update write path, and the lookup read path.
- Sits between those requesters and the status array macro. Registers the selected request onto the array port.
- Tracks in-flight reads and returns read data, tagged, to the lookup path.
- Prevents update starvation under continuous lookup traffic.

Parameters:
- ADDR_WIDTH, from shared_params.vh: status array row address width.
- ROW_WIDTH, from shared_params.vh: status array row width.
- NUM_BLOCKS, from shared_params.vh: write-mask width.
- RD_LATENCY, default 1: cycles from an array read accepted on the o_arr_* port to i_arr_rdata valid; legal range 1..4.
- TAG_WIDTH, default 4: width of the lookup tag carried alongside each read.
- STARVE_LIMIT, default 4: consecutive lookup grants allowed while an update waits.

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- i_halt  in  1  freeze: no grants are issued while high.
- i_init_complete  in  1  initializer done; level signal, stays high once set.
- i_init_addr  in  ADDR_WIDTH  initializer address.
- i_init_data  in  ROW_WIDTH  initializer data.
- i_init_wen  in  1  initializer write enable.
- i_init_wmask  in  NUM_BLOCKS  initializer write mask.
- i_init_valid  in  1  initializer request valid.
- i_upd_addr  in  ADDR_WIDTH  update address.
- i_upd_data  in  ROW_WIDTH  update data.
- i_upd_wmask  in  NUM_BLOCKS  update write mask.
- i_upd_valid  in  1  update write request.
- o_upd_ready  out  1  update accepted this cycle.
- i_lkp_addr  in  ADDR_WIDTH  lookup address.
- i_lkp_tag  in  TAG_WIDTH  lookup tag.
- i_lkp_valid  in  1  lookup read request.
- o_lkp_ready  out  1  lookup accepted this cycle.
- o_lkp_rdata  out  ROW_WIDTH  returned row.
- o_lkp_rtag  out  TAG_WIDTH  returned tag.
- o_lkp_rvalid  out  1  read response valid.
- o_arr_addr  out  ADDR_WIDTH  array address, registered.
- o_arr_data  out  ROW_WIDTH  array write data, registered.
- o_arr_wen  out  1  array write enable, registered.
- o_arr_wmask  out  NUM_BLOCKS  array write mask, registered.
- o_arr_valid  out  1  array request valid, registered.
- i_arr_rdata  in  ROW_WIDTH  array read data.

Behaviour:
- Reset (rst high at a clk edge):
  - state = S_INIT.
  - All o_arr_* = 0, o_lkp_rvalid = 0, o_lkp_rdata = 0, o_lkp_rtag = 0.
  - Starvation counter = 0; read pipeline cleared.
  - Reads in flight at reset never produce o_lkp_rvalid.
- Handshake: a request is accepted when valid && ready in the same cycle. The ready outputs are combinational from state, i_halt, the valids and the counter. At most one grant per cycle.
- S_INIT:
  - The init request passes through and registers onto o_arr_* one cycle later.
  - o_upd_ready = o_lkp_ready = 0.
  - i_init_complete=1 moves the FSM to S_RUN on the next edge; init inputs are ignored from then on.
- S_RUN grant rule:
  - Lookup has priority.
  - Update wins when no lookup is valid, or when starve_cnt == STARVE_LIMIT.
- Starvation counter (starve_cnt):
  - Increments on each lookup grant while i_upd_valid is high.
  - Clears on any update grant, or when i_upd_valid is low.
  - Saturates at STARVE_LIMIT.
- i_halt=1:
  - Both ready outputs are 0 and no grant is made, so o_arr_valid is 0 next cycle.
  - The state, starve_cnt and the read pipeline keep advancing; in-flight reads still return.
  - In S_INIT, the init request is also blocked.
- Array port:
  - On a grant, the next cycle drives o_arr_valid=1 with the granted fields. An update forces o_arr_wen=1; a lookup forces o_arr_wen=0, wmask=0, data=0.
  - With no grant: o_arr_valid=0, o_arr_wen=0, o_arr_wmask=0. Addr/data hold don't-care, and are driven to 0.
- Read pipeline:
  - A shift register of depth RD_LATENCY, carrying valid and tag.
  - Entry pushed when o_arr_valid && !o_arr_wen.
  - o_lkp_rvalid and o_lkp_rtag are asserted exactly RD_LATENCY cycles after the array request. o_lkp_rdata = i_arr_rdata in that cycle.
  - Total lookup latency from grant to rvalid = 1 + RD_LATENCY.
- Write-then-read to the same address in consecutive grants needs no special handling: array ordering is preserved by the single port.
- Simultaneous update and lookup with starve_cnt < STARVE_LIMIT: lookup granted, update waits.
- Update and lookup valid with no competition: the lone requester is granted in the same cycle.

Decomposition:
- Shared package / shared_params.vh:
  - ADDR_WIDTH, ROW_WIDTH, NUM_BLOCKS (existing).
  - New state encodings for S_INIT and S_RUN.
  - STATUS_RD_LATENCY default constant.
- One natural sub-module: status_read_tracker, the RD_LATENCY-deep valid/tag shift register with sync reset.

Test Plan:
- Reset then init: the initializer drives 2^ADDR_WIDTH writes with i_init_complete held low. Required: every write appears on o_arr_* one cycle later; o_upd_ready = o_lkp_ready = 0 throughout.
- Single lookup, RD_LATENCY=1, after init:
  - Lookup addr=5, tag=3, granted at cycle t.
  - Required: o_arr_valid=1 and wen=0 at t+1; o_lkp_rvalid=1 with rtag=3 at t+2; the array model's row returned.
- Starvation, STARVE_LIMIT=4: lookup and update both held valid. Required: grant order L,L,L,L,U,L,L,L,L,U…; starve_cnt resets after each U.
- Halt with reads in flight:
  - Issue 2 back-to-back lookups, then raise i_halt for 3 cycles.
  - Required: both responses still return in order; no o_arr_valid during the halt; grants resume the cycle after i_halt falls.
- Reset mid-operation: assert rst while 1 read is in flight. Required: no o_lkp_rvalid afterwards; state returns to S_INIT; all outputs are 0 on the next cycle.
- RD_LATENCY=3, 4 back-to-back lookups with tags 0..3. Required: rvalid on 4 consecutive cycles, rtag 0,1,2,3, each 4 cycles after its grant.
